// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: run-control, divisor-load and status bundle of the
// programmable clock divider.
//   en        run request (level)
//   div_in    new divisor value
//   div_load  one-cycle request to load div_in
//   clk_out   divided clock, registered
//   tick      one-cycle strobe in the first cycle of each output period
//   cur_div   divisor currently in effect
//   div_busy  a loaded divisor is waiting for the next period boundary
//   div_err   one-cycle pulse after a rejected load (div_in < 2)
// master: the controller driving the divider; slave: the divider itself.
interface clk_div_prog_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] cur_div;
  logic             div_busy;
  logic             div_err;

  modport master (
    output en, div_in, div_load,
    input  clk_out, tick, cur_div, div_busy, div_err
  );

  modport slave (
    input  en, div_in, div_load,
    output clk_out, tick, cur_div, div_busy, div_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider producing a registered divided
// clock and a period-start strobe from clk_in.
//   clk_in   sole clock, rising edge
//   reset    synchronous, active-high
//   bus      clk_div_prog_if.slave (en, div_in, div_load in;
//            clk_out, tick, cur_div, div_busy, div_err out)
// Parameters:
//   CNT_W        width of divisor and counter; legal divisors 2 .. 2^CNT_W-1
//   DEFAULT_DIV  divisor loaded at reset
// Divisor changes only take effect at a period wrap, and dropping en lets
// the period in progress finish, so clk_out never shows a runt pulse
// except when reset truncates it.
module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic           clk_in,
  input  logic           reset,
  clk_div_prog_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cur_div_reg, cur_div_next;
  logic [CNT_W-1:0] pend_div_reg, pend_div_next;
  logic             busy_reg, busy_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic             err_reg, err_next;

  logic             load_ok;
  logic             load_bad;
  logic             boundary;
  logic             running_next;
  logic [CNT_W:0]   half_next;

  always_comb begin
    load_ok  = bus.div_load && (bus.div_in >= CNT_W'(2));
    load_bad = bus.div_load && (bus.div_in <  CNT_W'(2));
    // Last cycle of the current period; the counter wraps on this edge.
    boundary = (state_reg != IDLE) && (cnt_reg == cur_div_reg - CNT_W'(1));

    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cur_div_next  = cur_div_reg;
    pend_div_next = pend_div_reg;
    busy_next     = busy_reg;
    err_next      = load_bad;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // Nothing is being generated, so a load applies at once.
        if (load_ok) begin
          cur_div_next = bus.div_in;
        end
        if (bus.en) begin
          state_next = RUN;
        end
      end
      default: begin
        if (boundary) begin
          cnt_next  = '0;
          busy_next = 1'b0;
          // A load landing on the wrap itself is newer than any pending one.
          if (load_ok) begin
            cur_div_next = bus.div_in;
          end else if (busy_reg) begin
            cur_div_next = pend_div_reg;
          end
          // Stop request at the wrap: the period just finished, go idle.
          state_next = bus.en ? RUN : IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (load_ok) begin
            pend_div_next = bus.div_in;
            busy_next     = 1'b1;
          end
          state_next = bus.en ? RUN : DRAIN;
        end
      end
    endcase

    // Outputs are computed from the next-state values so that the
    // registered clk_out/tick line up with the registered counter.
    running_next = (state_next != IDLE);
    half_next    = ({1'b0, cur_div_next} + (CNT_W+1)'(1)) >> 1;
    clk_out_next = running_next && ({1'b0, cnt_next} < half_next);
    tick_next    = running_next && (cnt_next == '0);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cur_div_reg  <= DEF_DIV;
      pend_div_reg <= DEF_DIV;
      busy_reg     <= 1'b0;
      clk_out_reg  <= 1'b0;
      tick_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cur_div_reg  <= cur_div_next;
      pend_div_reg <= pend_div_next;
      busy_reg     <= busy_next;
      clk_out_reg  <= clk_out_next;
      tick_reg     <= tick_next;
      err_reg      <= err_next;
    end
  end

  assign bus.clk_out  = clk_out_reg;
  assign bus.tick     = tick_reg;
  assign bus.cur_div  = cur_div_reg;
  assign bus.div_busy = busy_reg;
  assign bus.div_err  = err_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog (CNT_W=8, DEFAULT_DIV=6): a table of per-cycle
// input/expected-output records, followed by hand-written sequences for the
// 255 divisor and reset while a load is pending.
module tb_clk_div_prog;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_in = ~clk_in;

  clk_div_prog_if #(.CNT_W(8)) bus ();

  clk_div_prog #(
    .CNT_W       (8),
    .DEFAULT_DIV (6)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] din;
    logic       clk;
    logic       tick;
    logic [7:0] cur;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic en, input logic ld, input logic [7:0] din,
                              input logic clk, input logic tick, input logic [7:0] cur,
                              input logic busy, input logic err);
    vec_t v;
    v.en = en; v.ld = ld; v.din = din;
    v.clk = clk; v.tick = tick; v.cur = cur; v.busy = busy; v.err = err;
    vecs.push_back(v);
  endfunction

  function automatic logic [11:0] pk(input logic clk, input logic tick, input logic [7:0] cur,
                                     input logic busy, input logic err);
    return {clk, tick, cur, busy, err};
  endfunction

  function automatic logic [11:0] outs();
    return {bus.clk_out, bus.tick, bus.cur_div, bus.div_busy, bus.div_err};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic step(input logic e, input logic l, input logic [7:0] d);
    bus.en       = e;
    bus.div_load = l;
    bus.div_in   = d;
    @(posedge clk_in);
    #1;
  endtask

  int high_cnt, tick_cnt, first_low, tick2_at;

  initial begin
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;

    // en, ld, din | clk, tick, cur, busy, err
    // Default run, D=6; reload 5 at cnt=1
    add(1,0,0, 1,1,6,0,0); add(1,0,0, 1,0,6,0,0);
    add(1,1,5, 1,0,6,1,0); add(1,0,0, 0,0,6,1,0); add(1,0,0, 0,0,6,1,0);
    add(1,0,0, 0,0,6,1,0); add(1,0,0, 1,1,5,0,0);
    // D=5: 3 high / 2 low
    add(1,0,0, 1,0,5,0,0); add(1,0,0, 1,0,5,0,0); add(1,0,0, 0,0,5,0,0);
    add(1,0,0, 0,0,5,0,0); add(1,0,0, 1,1,5,0,0);
    // Rejected loads 0 and 1
    add(1,1,0, 1,0,5,0,1); add(1,1,1, 1,0,5,0,1); add(1,0,0, 0,0,5,0,0);
    add(1,0,0, 0,0,5,0,0); add(1,0,0, 1,1,5,0,0);
    // Load 4 then 7 in one period: 7 wins
    add(1,1,4, 1,0,5,1,0); add(1,1,7, 1,0,5,1,0); add(1,0,0, 0,0,5,1,0);
    add(1,0,0, 0,0,5,1,0); add(1,0,0, 1,1,7,0,0);
    // D=7: 4 high / 3 low
    add(1,0,0, 1,0,7,0,0); add(1,0,0, 1,0,7,0,0); add(1,0,0, 1,0,7,0,0);
    add(1,0,0, 0,0,7,0,0); add(1,0,0, 0,0,7,0,0); add(1,0,0, 0,0,7,0,0);
    add(1,0,0, 1,1,7,0,0);
    add(1,0,0, 1,0,7,0,0); add(1,0,0, 1,0,7,0,0); add(1,0,0, 1,0,7,0,0);
    add(1,0,0, 0,0,7,0,0); add(1,0,0, 0,0,7,0,0); add(1,0,0, 0,0,7,0,0);
    // Load 6 on the boundary cycle: applied at the wrap
    add(1,1,6, 1,1,6,0,0);
    // Clean stop at cnt=1
    add(1,0,0, 1,0,6,0,0); add(0,0,0, 1,0,6,0,0); add(0,0,0, 0,0,6,0,0);
    add(0,0,0, 0,0,6,0,0); add(0,0,0, 0,0,6,0,0); add(0,0,0, 0,0,6,0,0);
    add(0,0,0, 0,0,6,0,0);
    // Restart, drop en, re-raise at cnt=4: no gap, no extra tick
    add(1,0,0, 1,1,6,0,0); add(1,0,0, 1,0,6,0,0); add(0,0,0, 1,0,6,0,0);
    add(0,0,0, 0,0,6,0,0); add(0,0,0, 0,0,6,0,0); add(1,0,0, 0,0,6,0,0);
    add(1,0,0, 1,1,6,0,0); add(1,0,0, 1,0,6,0,0);
    // Stop, then load 2 while idle
    add(0,0,0, 1,0,6,0,0); add(0,0,0, 0,0,6,0,0); add(0,0,0, 0,0,6,0,0);
    add(0,0,0, 0,0,6,0,0); add(0,0,0, 0,0,6,0,0);
    add(0,1,2, 0,0,2,0,0);
    add(1,0,0, 1,1,2,0,0); add(1,0,0, 0,0,2,0,0); add(1,0,0, 1,1,2,0,0);
    add(1,0,0, 0,0,2,0,0);

    // Reset values
    reset = 1'b1;
    step(0,0,0);
    step(0,0,0);
    check("reset_state", outs(), pk(0,0,6,0,0));
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].ld, vecs[i].din);
      check($sformatf("vec%0d", i), outs(),
            pk(vecs[i].clk, vecs[i].tick, vecs[i].cur, vecs[i].busy, vecs[i].err));
    end

    // Divisor 255: stop, load while idle, run two periods
    for (int i = 0; i < 4; i++) step(0,0,0);
    check("d255_idle", outs(), pk(0,0,2,0,0));
    step(0,1,255);
    check("d255_load", outs(), pk(0,0,255,0,0));
    high_cnt = 0; tick_cnt = 0; first_low = -1; tick2_at = -1;
    for (int i = 0; i < 510; i++) begin
      step(1,0,0);
      if (i < 255 && bus.clk_out) high_cnt++;
      if (!bus.clk_out && first_low < 0) first_low = i;
      if (bus.tick) begin
        tick_cnt++;
        if (i > 0 && tick2_at < 0) tick2_at = i;
      end
    end
    check("d255_high_cycles", high_cnt, 128);
    check("d255_first_low", first_low, 128);
    check("d255_tick_count", tick_cnt, 2);
    check("d255_tick_period", tick2_at, 255);

    // Reset while a load is pending
    step(1,0,0);
    check("pend_wrap", outs(), pk(1,1,255,0,0));
    step(1,1,3);
    check("pend_busy", outs(), pk(1,0,255,1,0));
    reset = 1'b1;
    step(1,1,9);
    check("rst_prio_load", outs(), pk(0,0,6,0,0));
    step(1,1,0);
    check("rst_prio_err", outs(), pk(0,0,6,0,0));
    reset = 1'b0;
    step(1,0,0);
    check("rst_restart", outs(), pk(1,1,6,0,0));
    for (int i = 0; i < 5; i++) step(1,0,0);
    check("rst_last_low", outs(), pk(0,0,6,0,0));
    step(1,0,0);
    check("rst_next_tick", outs(), pk(1,1,6,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
